ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
Circular-buffer FIFO controller that drives the 4096 x 64 banked dual-port RAM (ram_4096) as its storage, turning it into a synchronous FIFO.
- Sits directly upstream of the RAM: generates wr_address, rd_address, write, read and data_in, and consumes data_out.
- Exposes a push/pop interface with full/empty, almost-full, occupancy count and sticky error flags.

Parameters:
RAM_WIDTH, 64, data word width; must match the RAM.
ADDR_SIZE, 12, RAM address width; FIFO depth is 2**ADDR_SIZE = 4096.
AFULL_THRESH, 4032, count at or above which almost_full asserts.

Ports:
clk  input  1  RAM and controller clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
push  input  1  write request; accepted when !full.
push_data  input  RAM_WIDTH  data to enqueue.
pop  input  1  read request; accepted when !empty.
pop_data  output  RAM_WIDTH  dequeued word; valid only while pop_valid=1.
pop_valid  output  1  high one cycle after an accepted pop.
full  output  1  count == 2**ADDR_SIZE.
empty  output  1  count == 0.
almost_full  output  1  count >= AFULL_THRESH.
count  output  ADDR_SIZE+1  current occupancy.
overflow  output  1  sticky; set by push while full.
underflow  output  1  sticky; set by pop while empty.
ram_data_in  output  RAM_WIDTH  to RAM data_in.
ram_wr_address  output  ADDR_SIZE  to RAM wr_address.
ram_rd_address  output  ADDR_SIZE  to RAM rd_address.
ram_write  output  1  to RAM write.
ram_read  output  1  to RAM read.
ram_data_out  input  RAM_WIDTH  from RAM data_out.

Behaviour:
Reset (rst_n=0 at a clk edge):
- Pointers and count go to 0; empty=1; full=0; almost_full=0; pop_valid=0; overflow=0; underflow=0.
- RAM contents are not cleared.
- Reset mid-operation discards all stored entries and any in-flight pop (pop_valid=0 on the next cycle).

Pointers:
- wr_ptr and rd_ptr are ADDR_SIZE+1 bits.
- The low ADDR_SIZE bits drive the RAM addresses; the MSB is the wrap bit.
- Both wrap from 4095 to 0 with the MSB toggled.

Push:
- push_acc = push & !full.
- ram_write = push_acc (combinational).
- ram_wr_address = wr_ptr[ADDR_SIZE-1:0]; ram_data_in = push_data.
- wr_ptr increments on the same edge.

Pop:
- pop_acc = pop & !empty.
- ram_read = pop_acc (combinational); ram_rd_address = rd_ptr[ADDR_SIZE-1:0].
- rd_ptr increments on the same edge.
- The RAM registers the data, so pop_valid is a registered copy of pop_acc.
- pop_data = ram_data_out (pass-through). Read latency is exactly 1 cycle.

Count:
- count_next = count + push_acc - pop_acc.
- Flags are decoded from registered count, not from the next value.
- Simultaneous push and pop:
  - When neither full nor empty, both are accepted and count is unchanged.
  - When empty, only the push is accepted and the pop is rejected (it raises underflow).
  - When full, only the pop is accepted and the push is rejected (it raises overflow).
  - Same-cycle write-then-read of one address never occurs.

Errors:
- overflow sets on push & full; underflow sets on pop & empty.
- Both hold until reset. Rejected requests do not touch pointers or the RAM.

Bank tri-state:
- When ram_read=0, RAM data_out may be Z or stale. Consumers sample pop_data only when pop_valid=1.

Fall-through:
- No bypass. Data pushed at cycle N is poppable at N+1 and appears on pop_data at N+2.

Test Plan:
- Reset then idle: after rst_n low for 2 cycles → empty=1, full=0, count=0, pop_valid=0, ram_write=0, ram_read=0 on every cycle.
- Push 0x0000_0000_0000_0001..0x...0003 on consecutive cycles, then pop 3 times → pop_valid high on 3 consecutive cycles carrying 1,2,3 in order; count returns to 0; empty=1.
- Push 4096 words of value = index → full=1 after the 4096th push; almost_full first asserts when count reaches 4032. Extra push → overflow=1, count stays 4096. Drain all 4096 → values 0..4095 in order, including across bank boundaries 1023/1024, 2047/2048 and 3071/3072.
- Wrap-around: push 4000, pop 4000, push 200, pop 200 → ram_wr_address passes 4095→0; popped data matches pushed data; wrap-bit handling keeps count correct (200 then 0).
- Simultaneous push+pop at count=10 for 50 cycles → count stays 10, outputs stay in order. Simultaneous push+pop at count=0 → push accepted, underflow=1, count=1, pop_valid=0 the next cycle.
- Assert rst_n=0 mid-drain with count=100 and pop active → next cycle count=0, empty=1, pop_valid=0, overflow=0, underflow=0. A subsequent push/pop of 0xDEAD_BEEF returns 0xDEAD_BEEF.

Source files
------------

// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop handshake and status bundle between a FIFO client and ram_fifo_ctrl.
interface ram_fifo_ctrl_if #(
  parameter int unsigned RAM_WIDTH = 64,
  parameter int unsigned ADDR_SIZE = 12
);
  logic                 push;
  logic [RAM_WIDTH-1:0] push_data;
  logic                 pop;
  logic [RAM_WIDTH-1:0] pop_data;
  logic                 pop_valid;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic [ADDR_SIZE:0]   count;
  logic                 overflow;
  logic                 underflow;

  // Client side: issues requests, observes data and status.
  modport master (
    output push, push_data, pop,
    input  pop_data, pop_valid, full, empty, almost_full, count, overflow, underflow
  );

  // Controller side.
  modport slave (
    input  push, push_data, pop,
    output pop_data, pop_valid, full, empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Circular-buffer FIFO controller driving a 2**ADDR_SIZE x RAM_WIDTH dual-port
// RAM with a registered read port. Pointers carry an extra wrap bit; occupancy
// is tracked in an explicit counter from which all flags are decoded.
module ram_fifo_ctrl #(
  parameter int unsigned RAM_WIDTH    = 64,
  parameter int unsigned ADDR_SIZE    = 12,
  parameter int unsigned AFULL_THRESH = 4032
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_fifo_ctrl_if.slave       fifo,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  output logic [ADDR_SIZE-1:0] ram_wr_address,
  output logic [ADDR_SIZE-1:0] ram_rd_address,
  output logic                 ram_write,
  output logic                 ram_read,
  input  logic [RAM_WIDTH-1:0] ram_data_out
);

  localparam logic [ADDR_SIZE:0] DEPTH     = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0] AFULL_LIM = AFULL_THRESH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] ONE       = {{ADDR_SIZE{1'b0}}, 1'b1};

  logic [ADDR_SIZE:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0] count_q, count_d;
  logic               pop_valid_q, pop_valid_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic full_w, empty_w, push_acc, pop_acc;

  // Status flags decoded from the registered occupancy.
  always_comb begin
    full_w   = (count_q == DEPTH);
    empty_w  = (count_q == '0);
    push_acc = fifo.push & ~full_w;
    pop_acc  = fifo.pop & ~empty_w;
  end

  // Next-state: pointers, occupancy, read-valid pipeline and sticky errors.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_valid_d = pop_acc;
    overflow_d  = overflow_q | (fifo.push & full_w);
    underflow_d = underflow_q | (fifo.pop & empty_w);
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end
    if (push_acc && !pop_acc) begin
      count_d = count_q + ONE;
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - ONE;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // RAM request side and client-facing outputs.
  always_comb begin
    ram_write        = push_acc;
    ram_read         = pop_acc;
    ram_wr_address   = wr_ptr_q[ADDR_SIZE-1:0];
    ram_rd_address   = rd_ptr_q[ADDR_SIZE-1:0];
    ram_data_in      = fifo.push_data;
    fifo.pop_data    = ram_data_out;
    fifo.pop_valid   = pop_valid_q;
    fifo.full        = full_w;
    fifo.empty       = empty_w;
    fifo.almost_full = (count_q >= AFULL_LIM);
    fifo.count       = count_q;
    fifo.overflow    = overflow_q;
    fifo.underflow   = underflow_q;
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural registered-read RAM.
module tb_ram_fifo_ctrl;
  localparam int unsigned W     = 64;
  localparam int unsigned A     = 12;
  localparam int unsigned DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.RAM_WIDTH(W), .ADDR_SIZE(A)) fifo ();

  logic [W-1:0] ram_data_in;
  logic [W-1:0] ram_data_out;
  logic [A-1:0] ram_wr_address;
  logic [A-1:0] ram_rd_address;
  logic         ram_write;
  logic         ram_read;

  ram_fifo_ctrl #(.RAM_WIDTH(W), .ADDR_SIZE(A), .AFULL_THRESH(4032)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo           (fifo),
    .ram_data_in    (ram_data_in),
    .ram_wr_address (ram_wr_address),
    .ram_rd_address (ram_rd_address),
    .ram_write      (ram_write),
    .ram_read       (ram_read),
    .ram_data_out   (ram_data_out)
  );

  // Storage model: synchronous write, registered read.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_write) mem[ram_wr_address] <= ram_data_in;
    if (ram_read)  ram_data_out <= mem[ram_rd_address];
  end

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic push_seq(input int unsigned n, input logic [63:0] base);
    for (int unsigned i = 0; i < n; i++) begin
      fifo.push      = 1'b1;
      fifo.push_data = base + 64'(i);
      step();
    end
    fifo.push = 1'b0;
  endtask

  task automatic pop_seq(input string tag, input int unsigned n, input logic [63:0] base);
    for (int unsigned i = 0; i < n; i++) begin
      fifo.pop = 1'b1;
      step();
      check({tag, "_valid"}, 64'(fifo.pop_valid), 64'd1);
      check({tag, "_data"}, fifo.pop_data, base + 64'(i));
    end
    fifo.pop = 1'b0;
  endtask

  initial begin
    fifo.push      = 1'b0;
    fifo.pop       = 1'b0;
    fifo.push_data = '0;

    // Reset then idle
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_wr", 64'(ram_write), 64'd0);
      check("rst_rd", 64'(ram_read), 64'd0);
      step();
    end
    rst_n = 1'b1;
    check("rst_empty", 64'(fifo.empty), 64'd1);
    check("rst_full", 64'(fifo.full), 64'd0);
    check("rst_af", 64'(fifo.almost_full), 64'd0);
    check("rst_count", 64'(fifo.count), 64'd0);
    check("rst_pv", 64'(fifo.pop_valid), 64'd0);
    check("rst_ovf", 64'(fifo.overflow), 64'd0);
    check("rst_unf", 64'(fifo.underflow), 64'd0);
    step();
    check("idle_pv", 64'(fifo.pop_valid), 64'd0);
    check("idle_count", 64'(fifo.count), 64'd0);

    // Three pushes, three pops
    push_seq(3, 64'd1);
    check("p3_count", 64'(fifo.count), 64'd3);
    pop_seq("p3", 3, 64'd1);
    check("p3_count0", 64'(fifo.count), 64'd0);
    check("p3_empty", 64'(fifo.empty), 64'd1);
    step();
    check("p3_pv_off", 64'(fifo.pop_valid), 64'd0);

    // Fill to full with value = index
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fifo.push      = 1'b1;
      fifo.push_data = 64'(i);
      step();
      if (i == 4030) check("af_4031", 64'(fifo.almost_full), 64'd0);
      if (i == 4031) check("af_4032", 64'(fifo.almost_full), 64'd1);
      if (i == 4094) check("full_4095", 64'(fifo.full), 64'd0);
    end
    check("full", 64'(fifo.full), 64'd1);
    check("full_count", 64'(fifo.count), 64'd4096);
    check("full_ovf0", 64'(fifo.overflow), 64'd0);
    fifo.push_data = 64'hFFFF;
    @(negedge clk);
    check("ovf_nowrite", 64'(ram_write), 64'd0);
    step();
    fifo.push = 1'b0;
    check("ovf", 64'(fifo.overflow), 64'd1);
    check("ovf_count", 64'(fifo.count), 64'd4096);
    pop_seq("drain", DEPTH, 64'd0);
    check("drain_empty", 64'(fifo.empty), 64'd1);
    check("drain_count", 64'(fifo.count), 64'd0);
    check("drain_ovf_sticky", 64'(fifo.overflow), 64'd1);

    // Wrap-around
    do_reset();
    push_seq(4000, 64'h1000_0000);
    pop_seq("wrap1", 4000, 64'h1000_0000);
    for (int unsigned i = 0; i < 200; i++) begin
      fifo.push      = 1'b1;
      fifo.push_data = 64'h2000_0000 + 64'(i);
      if (i == 95 || i == 96) begin
        @(negedge clk);
        check("wrap_addr", 64'(ram_wr_address), 64'((4000 + i) % 4096));
      end
      step();
    end
    fifo.push = 1'b0;
    check("wrap_count200", 64'(fifo.count), 64'd200);
    pop_seq("wrap2", 200, 64'h2000_0000);
    check("wrap_count0", 64'(fifo.count), 64'd0);
    check("wrap_empty", 64'(fifo.empty), 64'd1);

    // Simultaneous push+pop at count=10
    push_seq(10, 64'hB000);
    for (int unsigned j = 0; j < 50; j++) begin
      fifo.push      = 1'b1;
      fifo.push_data = 64'hB000 + 64'(10 + j);
      fifo.pop       = 1'b1;
      step();
      check("sim_valid", 64'(fifo.pop_valid), 64'd1);
      check("sim_data", fifo.pop_data, 64'hB000 + 64'(j));
      check("sim_count", 64'(fifo.count), 64'd10);
    end
    fifo.push = 1'b0;
    pop_seq("sim_tail", 10, 64'hB000 + 64'd50);
    check("sim_count0", 64'(fifo.count), 64'd0);
    check("sim_unf0", 64'(fifo.underflow), 64'd0);

    // Simultaneous push+pop while empty
    fifo.push      = 1'b1;
    fifo.push_data = 64'hC0;
    fifo.pop       = 1'b1;
    @(negedge clk);
    check("e_write", 64'(ram_write), 64'd1);
    check("e_read", 64'(ram_read), 64'd0);
    step();
    fifo.push = 1'b0;
    fifo.pop  = 1'b0;
    check("e_unf", 64'(fifo.underflow), 64'd1);
    check("e_count", 64'(fifo.count), 64'd1);
    check("e_pv", 64'(fifo.pop_valid), 64'd0);
    check("e_ovf", 64'(fifo.overflow), 64'd0);

    // Reset mid-drain with pop active
    push_seq(199, 64'hD000);
    check("md_count200", 64'(fifo.count), 64'd200);
    for (int unsigned i = 0; i < 100; i++) begin
      fifo.pop = 1'b1;
      step();
    end
    check("md_count100", 64'(fifo.count), 64'd100);
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    fifo.pop = 1'b0;
    check("md_count", 64'(fifo.count), 64'd0);
    check("md_empty", 64'(fifo.empty), 64'd1);
    check("md_pv", 64'(fifo.pop_valid), 64'd0);
    check("md_ovf", 64'(fifo.overflow), 64'd0);
    check("md_unf", 64'(fifo.underflow), 64'd0);
    push_seq(1, 64'hDEAD_BEEF);
    pop_seq("md_beef", 1, 64'hDEAD_BEEF);
    check("md_final_empty", 64'(fifo.empty), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
